// File: rtl/result_uart_dumper_if.sv
// Memory read path and dump control/status bundle for result_uart_dumper.
// The dumper takes the slave side; the controller and memory take the master side.
interface result_uart_dumper_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       word_count;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_q;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, word_count, mem_q,
        input  mem_addr, tx, busy, done
    );

    modport slave (
        input  start, base_addr, word_count, mem_q,
        output mem_addr, tx, busy, done
    );
endinterface

// File: rtl/result_uart_dumper.sv
// Walks a range of 32-bit shared memory and sends each word as four 8N1 UART
// bytes, lane 0 first, LSB first within each byte.
module result_uart_dumper #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned RD_LAT       = 1
) (
    input logic                clock,
    input logic                rst,
    result_uart_dumper_if.slave bus
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WAIT, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [1:0]        lane;
    logic [1:0]        lat_cnt;
    logic [31:0]       shift_word;
    logic [15:0]       remaining;
    logic [ADDR_W-1:0] addr_q;
    logic              baud_last;
    logic              lat_last;

    assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign lat_last  = (lat_cnt == 2'(RD_LAT - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nx = (bus.word_count == 16'd0) ? S_DONE : S_ADDR;
            S_ADDR:  state_nx = S_WAIT;
            S_WAIT:  if (lat_last) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_START;
            S_START: if (baud_last) state_nx = S_DATA;
            S_DATA:  if (baud_last && bit_idx == 3'd7) state_nx = S_STOP;
            S_STOP:  if (baud_last) state_nx = (lane == 2'd3) ? S_NEXT : S_START;
            S_NEXT:  state_nx = (remaining == 16'd1) ? S_DONE : S_ADDR;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            lane       <= '0;
            lat_cnt    <= '0;
            shift_word <= '0;
            remaining  <= '0;
            addr_q     <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    // A zero-length dump leaves the address register untouched.
                    if (bus.start && bus.word_count != 16'd0) begin
                        addr_q    <= bus.base_addr;
                        remaining <= bus.word_count;
                    end
                end
                S_WAIT: lat_cnt <= lat_last ? '0 : lat_cnt + 2'd1;
                S_LOAD: begin
                    shift_word <= bus.mem_q;
                    lane       <= '0;
                    bit_idx    <= '0;
                    baud_cnt   <= '0;
                end
                S_START: baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);
                S_DATA: begin
                    baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);
                    // Shifting the whole word brings the next lane down to bit 0 after 8 bits.
                    if (baud_last) begin
                        shift_word <= shift_word >> 1;
                        bit_idx    <= bit_idx + 3'd1;
                    end
                end
                S_STOP: begin
                    baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);
                    if (baud_last) lane <= lane + 2'd1;
                end
                S_NEXT: begin
                    remaining <= remaining - 16'd1;
                    if (remaining != 16'd1) addr_q <= addr_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.tx = 1'b1;
        unique case (state)
            S_START: bus.tx = 1'b0;
            S_DATA:  bus.tx = shift_word[0];
            default: bus.tx = 1'b1;
        endcase
    end

    assign bus.mem_addr = addr_q;
    assign bus.busy     = (state != S_IDLE) && (state != S_DONE);
    assign bus.done     = (state == S_DONE);
endmodule

// File: tb/tb_result_uart_dumper.sv
// Directed bench for result_uart_dumper: a cycle-level waveform model built from
// the frame/word timing rules, an independent UART receiver, and literal checks.
module tb_result_uart_dumper;
    localparam int CPB = 4;
    localparam int LAT = 1;

    typedef struct {
        logic        tx;
        logic        busy;
        logic        done;
        logic [15:0] addr;
    } exp_t;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    result_uart_dumper_if #(.ADDR_W(16)) bus ();

    result_uart_dumper #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(16),
        .RD_LAT(LAT)
    ) dut (
        .clock(clock),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem [0:65535];
    always @(posedge clock) bus.mem_q <= mem[bus.mem_addr];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          t_acc = 0;
    logic        check_en = 1'b0;
    logic        rx_en = 1'b0;
    logic        last_cycle_idle = 1'b1;
    logic [15:0] idle_addr = 16'h0000;
    exp_t        exp_q[$];
    logic [7:0]  rx_q[$];
    logic [15:0] addr_seen[$];
    logic [7:0]  rx_byte;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void push_exp(logic t, logic b, logic d, logic [15:0] a);
        exp_t e;
        e.tx = t; e.busy = b; e.done = d; e.addr = a;
        exp_q.push_back(e);
    endfunction

    // Expected per-cycle outputs of one dump, starting with the cycle after the accepting edge.
    function automatic void model_dump(logic [15:0] base, int unsigned count);
        logic [15:0] a;
        logic [31:0] w;
        logic [9:0]  frame;
        a = idle_addr;
        for (int unsigned k = 0; k < count; k++) begin
            a = base + 16'(k);
            repeat (LAT + 2) push_exp(1'b1, 1'b1, 1'b0, a);
            w = mem[a];
            for (int l = 0; l < 4; l++) begin
                frame = {1'b1, w[8*l +: 8], 1'b0};
                for (int b = 0; b < 10; b++) repeat (CPB) push_exp(frame[b], 1'b1, 1'b0, a);
            end
            push_exp(1'b1, 1'b1, 1'b0, a);
        end
        push_exp(1'b1, 1'b0, 1'b1, a);
        idle_addr = a;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (check_en) begin
            last_cycle_idle = (exp_q.size() == 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
            end else begin
                e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.addr = idle_addr;
            end
            chk("cyc_tx",       64'(bus.tx),       64'(e.tx));
            chk("cyc_busy",     64'(bus.busy),     64'(e.busy));
            chk("cyc_done",     64'(bus.done),     64'(e.done));
            chk("cyc_mem_addr", 64'(bus.mem_addr), 64'(e.addr));
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.busy === 1'b1 && (addr_seen.size() == 0 || addr_seen[$] !== bus.mem_addr))
                addr_seen.push_back(bus.mem_addr);
        end
    end

    // Independent mid-bit sampling receiver.
    always begin
        @(negedge clock);
        if (rx_en && bus.tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clock);
                rx_byte[i] = bus.tx;
            end
            repeat (CPB) @(negedge clock);
            if (bus.tx === 1'b1) rx_q.push_back(rx_byte);
        end
    end

    task automatic do_start(input logic [15:0] base, input logic [15:0] count);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = count;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        if (last_cycle_idle) begin
            t_acc = cyc;
            model_dump(base, int'(count));
        end
    endtask

    task automatic wait_done(input string name, input int d0, input int budget, input int lat);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) break;
            @(posedge clock);
        end
        #1;
        chk({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_latency"}, 64'(done_cyc - t_acc), 64'(lat));
    endtask

    task automatic chk_rx(input string name, input int n, input logic [95:0] bytes);
        chk({name, "_rx_count"}, 64'(rx_q.size()), 64'(n));
        for (int i = 0; i < n; i++)
            if (i < rx_q.size()) chk({name, "_rx_byte"}, 64'(rx_q[i]), 64'(bytes[8*i +: 8]));
    endtask

    task automatic chk_addrs(input string name, input int n, input logic [47:0] addrs);
        chk({name, "_addr_count"}, 64'(addr_seen.size()), 64'(n));
        for (int i = 0; i < n; i++)
            if (i < addr_seen.size()) chk({name, "_addr"}, 64'(addr_seen[i]), 64'(addrs[16*i +: 16]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'h0010] = 32'hA5C3_0F81;
        mem[16'hFFFE] = 32'h1111_1111;
        mem[16'hFFFF] = 32'h2222_2222;
        mem[16'h0000] = 32'h3333_3333;
        mem[16'h0030] = 32'hDEAD_BEEF;
        mem[16'h0031] = 32'h0102_0304;
        mem[16'h0040] = 32'hFFFF_FFFF;
        mem[16'h0050] = 32'h1234_5678;
        mem[16'h0020] = 32'hCAFE_F00D;

        repeat (2) @(posedge clock);
        #1;
        chk("reset_tx", 64'(bus.tx), 64'd1);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
        rst = 1'b0;
        check_en = 1'b1;
        rx_en = 1'b1;

        // start coinciding with rst is ignored
        rst = 1'b1;
        bus.start = 1'b1; bus.base_addr = 16'h0060; bus.word_count = 16'd1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("rst_start_busy", 64'(bus.busy), 64'd0);
        chk("rst_start_no_done", 64'(done_cnt), 64'd0);

        // single word
        rx_q.delete(); addr_seen.delete();
        d0 = done_cnt;
        do_start(16'h0010, 16'd1);
        wait_done("single", d0, 400, 164);
        chk_rx("single", 4, 96'hA5C3_0F81);
        chk_addrs("single", 1, 48'h0010);

        // zero count, with start held into the DONE cycle
        rx_q.delete(); addr_seen.delete();
        d0 = done_cnt;
        do_start(16'h0077, 16'd0);
        do_start(16'h0077, 16'd0);
        repeat (10) @(posedge clock);
        #1;
        chk("zero_done_count", 64'(done_cnt - d0), 64'd1);
        chk("zero_latency", 64'(done_cyc - t_acc), 64'd0);
        chk("zero_rx_count", 64'(rx_q.size()), 64'd0);
        chk("zero_addr_seen", 64'(addr_seen.size()), 64'd0);
        chk("zero_mem_addr", 64'(bus.mem_addr), 64'h0010);

        // multi-word with address wrap
        rx_q.delete(); addr_seen.delete();
        d0 = done_cnt;
        do_start(16'hFFFE, 16'd3);
        wait_done("wrap", d0, 1000, 492);
        chk_rx("wrap", 12, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        chk_addrs("wrap", 3, {16'h0000, 16'hFFFF, 16'hFFFE});

        // start while busy is ignored
        rx_q.delete(); addr_seen.delete();
        d0 = done_cnt;
        do_start(16'h0030, 16'd2);
        repeat (50) @(posedge clock);
        #1;
        do_start(16'h0040, 16'd1);
        wait_done("busy_start", d0, 800, 328);
        repeat (400) @(posedge clock);
        #1;
        chk("busy_start_single_done", 64'(done_cnt - d0), 64'd1);
        chk_rx("busy_start", 8, {32'h0, 32'h0102_0304, 32'hDEAD_BEEF});
        chk_addrs("busy_start", 2, {16'h0, 16'h0031, 16'h0030});

        // reset during data bit 3 of byte 2, then a clean dump
        d0 = done_cnt;
        do_start(16'h0050, 16'd1);
        repeat (100) @(posedge clock);
        #1;
        chk("midframe_tx_before_rst", 64'(bus.tx), 64'd0);
        rst = 1'b1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        exp_q.delete();
        idle_addr = 16'h0000;
        chk("midframe_rst_tx", 64'(bus.tx), 64'd1);
        chk("midframe_rst_busy", 64'(bus.busy), 64'd0);
        chk("midframe_rst_done", 64'(bus.done), 64'd0);
        chk("midframe_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        repeat (60) @(posedge clock);
        #1;
        chk("midframe_no_done", 64'(done_cnt - d0), 64'd0);
        rx_q.delete(); addr_seen.delete();
        d0 = done_cnt;
        do_start(16'h0020, 16'd1);
        wait_done("after_rst", d0, 400, 164);
        chk_rx("after_rst", 4, 96'hCAFE_F00D);
        chk_addrs("after_rst", 1, 48'h0020);

        repeat (5) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/result_uart_dumper.md
Name: result_uart_dumper

Overview:
- Read-side counterpart to the cores' writes into shared data memory.
- After the cores finish, this block walks a range of the 32-bit shared memory, reading one word at a time.
- It serializes each word as four bytes on an 8N1 UART TX line, so results can be dumped to a host.
- It sits beside the state controller. It owns the memory address/read path while the cores are idle; the top level muxes its address onto the memory and holds the write enable low.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (≥2)
ADDR_W, 16, memory address width
RD_LAT, 1, clock cycles from address driven to mem_q valid (1..3)

Ports:
clock  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin dump (ignored while busy)
base_addr  input  ADDR_W  first word address, sampled on accepted start
word_count  input  16  number of 32-bit words to dump, sampled on accepted start
mem_addr  output  ADDR_W  read address to shared memory
mem_q  input  32  memory read data; lane k = bits 8k+7:8k = core k
tx  output  1  UART serial out, idle high
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when dump completes

Behaviour:
- Reset values: tx=1, busy=0, done=0, mem_addr=0, FSM=IDLE, all counters 0. Reset asserted in any state returns all outputs to these values on the same rising edge. A partially sent byte is abandoned; no stop bit is completed.
- Accepting start: start is accepted only in IDLE. On acceptance:
  - latch base_addr and word_count;
  - busy=1 from the next cycle.
- Zero-length dump: if word_count==0, go IDLE→DONE. done pulses on the cycle after start; tx never leaves 1.
- FSM states: IDLE, ADDR, WAIT, LOAD, START, DATA, STOP, NEXT, DONE.
- ADDR: drive mem_addr=current address; go to WAIT.
- WAIT: hold mem_addr for RD_LAT cycles.
- LOAD: capture mem_q into a 32-bit shift word; lane index=0.
- Byte order: lane 0 (bits 7:0) first, then 15:8, 23:16, 31:24.
- Each byte frame:
  - START: tx=0 for CLKS_PER_BIT cycles;
  - DATA: 8 data bits LSB first, each CLKS_PER_BIT cycles;
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Bytes within a word are back-to-back: stop bit followed directly by the next start bit, no idle gap.
- NEXT, entered after lane 3's stop bit:
  - decrement the remaining count;
  - if zero → DONE, else increment address → ADDR.
  - The one-cycle gap between words keeps tx=1.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF + 1 = 0x0000, no error.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
- mem_addr holds its last value when not in ADDR/WAIT.
- Timing:
  - Frame length is exactly 10·CLKS_PER_BIT cycles.
  - Words=N>0 takes N·(4·10·CLKS_PER_BIT + RD_LAT + 3) cycles from start to done, ±1 (exact constant fixed by the state sequence above; the bench checks it exactly).
- Start asserted in the DONE cycle is ignored. start asserted together with rst is ignored.
- mem_q is sampled only in LOAD. Changes at other times have no effect.
- Inputs base_addr/word_count changing while busy have no effect.

Test Plan:
- Reset values: CLKS_PER_BIT=4, RD_LAT=1. Assert rst for 2 cycles → tx=1, busy=0, done=0, mem_addr=0.
- Single word:
  - Stimulus: memory[0x0010]=0xA5C3_0F81; start with base_addr=0x0010, word_count=1.
  - Required: mem_addr=0x0010; tx decodes bytes 0x81, 0x0F, 0xC3, 0xA5 in order, each with start=0 and stop=1 of 4 cycles.
  - Required: done pulses once; busy falls with done.
- Multi-word with wrap:
  - Stimulus: base_addr=0xFFFE, word_count=3; memory holds 0x11111111, 0x22222222, 0x33333333 at 0xFFFE, 0xFFFF, 0x0000.
  - Required: address sequence 0xFFFE, 0xFFFF, 0x0000; 12 bytes received correctly; one done.
- Zero count: start with word_count=0 → done the next cycle; tx stays 1 throughout; mem_addr unchanged.
- Start while busy:
  - Stimulus: second start mid-dump with different base_addr.
  - Required: ignored; only the original range is sent; exactly one done.
- Reset mid-frame:
  - Stimulus: assert rst during data bit 3 of byte 2.
  - Required: tx=1 and busy=0 on that edge.
  - Then: a new start with base_addr=0x0020, word_count=1 dumps correctly.
